// File: rtl/irq_req_controller_if.sv
// Core-side request/acknowledge handshake of the interrupt request controller.
//   master : controller side (drives irq_out, irq_id_o, in_service_o)
//   slave  : core side (drives trap_ack_i, mret_i)
//   irq_out      registered request into the decoder irq_in
//   irq_id_o     ID of the requesting or in-service source
//   in_service_o high while a handler is active
//   trap_ack_i   one-cycle pulse, trap taken for the current request
//   mret_i       one-cycle pulse, handler returned
interface irq_req_controller_if #(
  parameter int unsigned ID_W = 3
);
  logic            irq_out;
  logic [ID_W-1:0] irq_id_o;
  logic            in_service_o;
  logic            trap_ack_i;
  logic            mret_i;

  modport master (
    output irq_out,
    output irq_id_o,
    output in_service_o,
    input  trap_ack_i,
    input  mret_i
  );

  modport slave (
    input  irq_out,
    input  irq_id_o,
    input  in_service_o,
    output trap_ack_i,
    output mret_i
  );
endinterface

// File: rtl/irq_req_controller.sv
// Interrupt request front-end feeding the control decoder irq_in.
// Synchronises NUM_SRC async lines, tracks pending state (level or rising
// edge per EDGE_MASK), masks with per-source/global enables, picks the lowest
// index and holds the request until trap_ack, then blocks until mret.
// Ports:
//   clk, rst        core clock, async active-high reset
//   irq_src         raw asynchronous interrupt lines
//   irq_en_i        per-source enable mask
//   global_ie_i     global interrupt enable
//   pending_o       registered pending vector
//   bus (master)    irq_out / irq_id_o / in_service_o / trap_ack_i / mret_i
// Optional macro IRQ_COUNT_EN adds irq_count_clr_i (sync clear) and
// irq_count_o (saturating count of accepted trap acks).
module irq_req_controller #(
  parameter int unsigned        NUM_SRC     = 8,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [NUM_SRC-1:0]   irq_en_i,
  input  logic                 global_ie_i,
  output logic [NUM_SRC-1:0]   pending_o,
  irq_req_controller_if.master bus
`ifdef IRQ_COUNT_EN
  ,
  input  logic                 irq_count_clr_i,
  output logic [31:0]          irq_count_o
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] line_q;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               accept;

  state_t          state_q, state_n;
  logic            irq_q, irq_n;
  logic [ID_W-1:0] id_q, id_n;
  logic            svc_q, svc_n;

  // Input synchronisers; line_q retimes the last stage so that level and
  // edge paths both observe the same settled sample one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      line_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      line_q <= sync_q[SYNC_STAGES-1];
      prev_q <= line_q;
    end
  end

  assign rise   = line_q & ~prev_q;
  assign accept = (state_q == REQ) && bus.trap_ack_i;
  assign clr    = accept ? (NUM_SRC'(1) << id_q) : '0;

  // Pending update: level follows the line; edge is sticky, set beats clear.
  always_comb begin
    pending_n = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (EDGE_MASK[i]) pending_n[i] = rise[i] | (pending_q[i] & ~clr[i]);
      else              pending_n[i] = line_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_n;
  end

  assign cand = pending_q & irq_en_i & {NUM_SRC{global_ie_i}};

  // Fixed priority: scanning downwards leaves the lowest set index.
  always_comb begin
    win_id  = '0;
    win_any = |cand;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      svc_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      irq_q   <= irq_n;
      id_q    <= id_n;
      svc_q   <= svc_n;
    end
  end

  // Next state; in REQ the ack is checked before withdrawal so it wins.
  always_comb begin
    state_n = state_q;
    irq_n   = 1'b0;
    id_n    = id_q;
    svc_n   = svc_q;
    case (state_q)
      IDLE: begin
        svc_n = 1'b0;
        if (win_any) begin
          state_n = REQ;
          irq_n   = 1'b1;
          id_n    = win_id;
        end
      end
      REQ: begin
        if (bus.trap_ack_i) begin
          state_n = SERVICE;
          svc_n   = 1'b1;
        end else if (!cand[id_q]) begin
          state_n = IDLE;
        end else begin
          irq_n = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.mret_i) begin
          state_n = IDLE;
          svc_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        svc_n   = 1'b0;
      end
    endcase
  end

  assign pending_o        = pending_q;
  assign bus.irq_out      = irq_q;
  assign bus.irq_id_o     = id_q;
  assign bus.in_service_o = svc_q;

`ifdef IRQ_COUNT_EN
  // Saturating count of accepted acks; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     irq_count_o <= '0;
    else if (irq_count_clr_i)                    irq_count_o <= '0;
    else if (accept && (irq_count_o != '1))      irq_count_o <= irq_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_irq_req_controller.sv
// Self-checking bench for irq_req_controller: a vector table for the basic
// level request/ack/mret flow plus hand sequences for priority freeze, edge
// sources, withdrawal, async reset and the optional counter.
module tb_irq_req_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src;
  logic [7:0] irq_en;
  logic       gie;
  logic [7:0] pending;
`ifdef IRQ_COUNT_EN
  logic        cnt_clr;
  logic [31:0] cnt;
`endif

  int checks   = 0;
  int failures = 0;

  irq_req_controller_if #(.ID_W(3)) bus ();

  irq_req_controller #(
    .NUM_SRC    (8),
    .SYNC_STAGES(2),
    .EDGE_MASK  (8'b0000_0010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .irq_en_i   (irq_en),
    .global_ie_i(gie),
    .pending_o  (pending),
    .bus        (bus)
`ifdef IRQ_COUNT_EN
    ,
    .irq_count_clr_i(cnt_clr),
    .irq_count_o    (cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] src;
    logic       ack;
    logic       mret;
    logic       exp_irq;
    logic [2:0] exp_id;
    logic [7:0] exp_pend;
    logic       exp_svc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    irq_src        = '0;
    irq_en         = 8'hFF;
    gie            = 1'b1;
    bus.trap_ack_i = 1'b0;
    bus.mret_i     = 1'b0;
`ifdef IRQ_COUNT_EN
    cnt_clr        = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int max);
    int n = 0;
    while (!bus.irq_out && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(bus.irq_out), 32'd1);
  endtask

  initial begin
    // Level source 3 through request, ack, mret, re-request, final drain.
    vecs[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[2]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[3]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0};
    vecs[4]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[5]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[6]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 8'h08, 1'b1};
    vecs[7]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd3, 8'h08, 1'b1};
    vecs[8]  = '{8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 8'h08, 1'b0};
    vecs[9]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h08, 1'b1};
    vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h08, 1'b1};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h08, 1'b1};
    vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b1};
    vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
    vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0};

    do_reset();
    check("reset_irq",  32'(bus.irq_out), 32'd0);
    check("reset_id",   32'(bus.irq_id_o), 32'd0);
    check("reset_pend", 32'(pending), 32'd0);
    check("reset_svc",  32'(bus.in_service_o), 32'd0);

    for (int i = 0; i < 16; i++) begin
      irq_src        = vecs[i].src;
      bus.trap_ack_i = vecs[i].ack;
      bus.mret_i     = vecs[i].mret;
      tick();
      check($sformatf("vec%0d_irq", i),  32'(bus.irq_out),      32'(vecs[i].exp_irq));
      check($sformatf("vec%0d_id", i),   32'(bus.irq_id_o),     32'(vecs[i].exp_id));
      check($sformatf("vec%0d_pend", i), 32'(pending),          32'(vecs[i].exp_pend));
      check($sformatf("vec%0d_svc", i),  32'(bus.in_service_o), 32'(vecs[i].exp_svc));
    end
    bus.trap_ack_i = 1'b0;
    bus.mret_i     = 1'b0;

    // Priority and freeze: 5 and 2 together, then 0 arrives during REQ.
    do_reset();
    irq_src = 8'h24;
    wait_irq("prio_wait", 10);
    check("prio_id", 32'(bus.irq_id_o), 32'd2);
    irq_src = 8'h25;
    repeat (6) tick();
    check("freeze_irq", 32'(bus.irq_out), 32'd1);
    check("freeze_id",  32'(bus.irq_id_o), 32'd2);
    bus.trap_ack_i = 1'b1; tick(); bus.trap_ack_i = 1'b0;
    check("freeze_ack_svc", 32'(bus.in_service_o), 32'd1);
    check("freeze_ack_id",  32'(bus.irq_id_o), 32'd2);
    bus.mret_i = 1'b1; tick(); bus.mret_i = 1'b0;
    check("prio_mret_irq", 32'(bus.irq_out), 32'd0);
    tick();
    check("prio_next_irq", 32'(bus.irq_out), 32'd1);
    check("prio_next_id",  32'(bus.irq_id_o), 32'd0);

    // Edge source 1: one-cycle pulse is latched until its ack.
    do_reset();
    irq_src = 8'h02; tick(); irq_src = 8'h00;
    tick(); tick();
    check("edge_pend_early", 32'(pending), 32'd0);
    tick();
    check("edge_pend_set", 32'(pending), 32'h02);
    tick();
    check("edge_irq", 32'(bus.irq_out), 32'd1);
    check("edge_id",  32'(bus.irq_id_o), 32'd1);
    repeat (3) tick();
    check("edge_pend_hold", 32'(pending), 32'h02);
    bus.trap_ack_i = 1'b1; tick(); bus.trap_ack_i = 1'b0;
    check("edge_pend_clr", 32'(pending), 32'h00);
    check("edge_ack_svc",  32'(bus.in_service_o), 32'd1);
    bus.mret_i = 1'b1; tick(); bus.mret_i = 1'b0;
    tick();
    check("edge_idle_irq", 32'(bus.irq_out), 32'd0);
    // New edge landing on the ack edge: set wins over clear.
    irq_src = 8'h02; tick(); irq_src = 8'h00;
    wait_irq("edge2_wait", 10);
    irq_src = 8'h02; tick(); irq_src = 8'h00;
    tick(); tick();
    bus.trap_ack_i = 1'b1; tick(); bus.trap_ack_i = 1'b0;
    check("edge_setwins_pend", 32'(pending), 32'h02);
    check("edge_setwins_svc",  32'(bus.in_service_o), 32'd1);
    bus.mret_i = 1'b1; tick(); bus.mret_i = 1'b0;
    tick();
    check("edge_rereq_irq", 32'(bus.irq_out), 32'd1);
    check("edge_rereq_id",  32'(bus.irq_id_o), 32'd1);

    // Withdrawal via global enable, then resume.
    do_reset();
    irq_src = 8'h08;
    wait_irq("wd_wait", 10);
    gie = 1'b0; tick();
    check("wd_irq", 32'(bus.irq_out), 32'd0);
    check("wd_svc", 32'(bus.in_service_o), 32'd0);
    tick();
    check("wd_idle_irq", 32'(bus.irq_out), 32'd0);
    gie = 1'b1; tick();
    check("wd_resume_irq", 32'(bus.irq_out), 32'd1);
    check("wd_resume_id",  32'(bus.irq_id_o), 32'd3);

    // Async reset while in SERVICE, level source still high afterwards.
    bus.trap_ack_i = 1'b1; tick(); bus.trap_ack_i = 1'b0;
    check("rst_pre_svc", 32'(bus.in_service_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_irq",  32'(bus.irq_out), 32'd0);
    check("rst_async_svc",  32'(bus.in_service_o), 32'd0);
    check("rst_async_pend", 32'(pending), 32'd0);
    check("rst_async_id",   32'(bus.irq_id_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check("rst_lat_early", 32'(bus.irq_out), 32'd0);
    tick();
    check("rst_lat_irq", 32'(bus.irq_out), 32'd1);

`ifdef IRQ_COUNT_EN
    // Three accepted acks, then clear racing an ack.
    do_reset();
    irq_src = 8'h08;
    for (int k = 0; k < 3; k++) begin
      wait_irq($sformatf("cnt_wait%0d", k), 10);
      bus.trap_ack_i = 1'b1; tick(); bus.trap_ack_i = 1'b0;
      bus.mret_i = 1'b1; tick(); bus.mret_i = 1'b0;
    end
    check("cnt_three", cnt, 32'd3);
    wait_irq("cnt_wait_clr", 10);
    cnt_clr = 1'b1; bus.trap_ack_i = 1'b1; tick();
    cnt_clr = 1'b0; bus.trap_ack_i = 1'b0;
    check("cnt_clr", cnt, 32'd0);
    check("cnt_clr_svc", 32'(bus.in_service_o), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
